// File: rtl/usr_deserializer.sv
// usr_deserializer: serial/parallel word collector with a valid/ready output.
// Optional even-parity check on streamed words via USR_DESER_PARITY_EN.
module usr_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     sel,
  input  logic                           sin,
  input  logic                           sin_valid,
  input  logic [WIDTH-1:0]               pin,
  output logic [WIDTH-1:0]               pout,
  output logic                           pout_valid,
  input  logic                           pout_ready,
  input  logic                           ovr_clr,
  output logic                           overrun,
  output logic [$clog2(WIDTH+1)-1:0]     bit_cnt,
  output logic                           parity_err
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
`ifdef USR_DESER_PARITY_EN
  localparam logic [CW-1:0] PBIT = CW'(WIDTH);
`endif

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_RGT  = 2'b01;
  localparam logic [1:0] SEL_LFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic {EMPTY, FULL} ost_e;

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             perr_q, perr_d;
  logic             offer;
  logic [WIDTH-1:0] offer_word;
  logic [WIDTH-1:0] base;
  logic [CW-1:0]    base_cnt;
  logic [WIDTH-1:0] shifted;
  ost_e             ost_q;
  logic [WIDTH-1:0] pout_q;
  logic             ovr_q;

  // Collector next-state: shift, count, direction tracking and word offer
  always_comb begin
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    perr_d     = 1'b0;
    offer      = 1'b0;
    offer_word = '0;
    base       = sreg_q;
    base_cnt   = cnt_q;
    shifted    = sreg_q;
    if (sin_valid) begin
      unique case (sel)
        SEL_LOAD: begin
          offer      = 1'b1;
          offer_word = pin;
          cnt_d      = '0;
        end
        SEL_RGT, SEL_LFT: begin
          dir_d = sel;
          if (sel != dir_q) begin
            base     = '0;
            base_cnt = '0;
          end
          if (sel == SEL_RGT)
            shifted = {sin, base[WIDTH-1:1]};
          else
            shifted = {base[WIDTH-2:0], sin};
`ifdef USR_DESER_PARITY_EN
          if (base_cnt == PBIT) begin
            cnt_d = '0;
            if ((^sreg_q) == sin) begin
              offer      = 1'b1;
              offer_word = sreg_q;
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            sreg_d = shifted;
            cnt_d  = base_cnt + 1'b1;
          end
`else
          sreg_d = shifted;
          if (base_cnt == LAST) begin
            cnt_d      = '0;
            offer      = 1'b1;
            offer_word = shifted;
          end else begin
            cnt_d = base_cnt + 1'b1;
          end
`endif
        end
        SEL_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Collector registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      dir_q  <= SEL_RGT;
      perr_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      perr_q <= perr_d;
    end
  end

  // Output stage FSM with sticky overrun (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ost_q  <= EMPTY;
      pout_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (ovr_clr)
        ovr_q <= 1'b0;
      unique case (ost_q)
        EMPTY: begin
          if (offer) begin
            pout_q <= offer_word;
            ost_q  <= FULL;
          end
        end
        FULL: begin
          if (offer) begin
            if (pout_ready)
              pout_q <= offer_word;
            else
              ovr_q <= 1'b1;
          end else if (pout_ready) begin
            ost_q <= EMPTY;
          end
        end
        default: ost_q <= EMPTY;
      endcase
    end
  end

  assign pout       = pout_q;
  assign pout_valid = (ost_q == FULL);
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;
`ifdef USR_DESER_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_q ^ perr_d;
`endif

endmodule

// File: tb/tb_usr_deserializer.sv
// tb_usr_deserializer: directed table of per-cycle vectors
// plus hand-written reset sequences, WIDTH=4.
module tb_usr_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       sin;
  logic       sin_valid;
  logic [3:0] pin;
  logic [3:0] pout;
  logic       pout_valid;
  logic       pout_ready;
  logic       ovr_clr;
  logic       overrun;
  logic [2:0] bit_cnt;
  logic       parity_err;

  int tests = 0;
  int fails = 0;

  usr_deserializer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .sin(sin),
    .sin_valid(sin_valid), .pin(pin), .pout(pout),
    .pout_valid(pout_valid), .pout_ready(pout_ready),
    .ovr_clr(ovr_clr), .overrun(overrun),
    .bit_cnt(bit_cnt), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       sin;
    logic       sv;
    logic [3:0] pin;
    logic       rdy;
    logic       clr;
    logic [3:0] ep;
    logic       ev;
    logic       eo;
    logic [2:0] ec;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [1:0] s, logic b, logic v,
                              logic [3:0] p, logic r, logic c,
                              logic [3:0] ep, logic ev,
                              logic eo, logic [2:0] ec);
    vec_t x;
    x.sel = s; x.sin = b; x.sv = v; x.pin = p;
    x.rdy = r; x.clr = c; x.ep = ep; x.ev = ev;
    x.eo = eo; x.ec = ec;
    return x;
  endfunction

  task automatic check(string nm, logic [3:0] ep, logic ev,
                       logic eo, logic [2:0] ec);
    tests++;
    if (pout !== ep || pout_valid !== ev || overrun !== eo ||
        bit_cnt !== ec || parity_err !== 1'b0) begin
      fails++;
      $display("FAIL %s: got pout=%h v=%b ovr=%b cnt=%0d perr=%b, want pout=%h v=%b ovr=%b cnt=%0d perr=0",
               nm, pout, pout_valid, overrun, bit_cnt, parity_err,
               ep, ev, eo, ec);
    end
  endtask

  task automatic drive(logic [1:0] s, logic b, logic v,
                       logic [3:0] p, logic r, logic c);
    sel = s; sin = b; sin_valid = v;
    pin = p; pout_ready = r; ovr_clr = c;
  endtask

  initial begin
    drive(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 4'h0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;

    // two partial bits, then async reset mid-cycle
    @(negedge clk);
    drive(2'b01, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("partial", 4'h0, 1'b0, 1'b0, 3'd2);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 4'h0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_release", 4'h0, 1'b0, 1'b0, 3'd0);

    // LSB-first 1010
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h0,0,0,1));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h0,0,0,2));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h0,0,0,3));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'hA,1,0,0));
    tv.push_back(mk(2'b00,0,0,0,1,0, 4'hA,0,0,0));
    // MSB-first 1010 with a 2-cycle gap
    tv.push_back(mk(2'b10,1,1,0,0,0, 4'hA,0,0,1));
    tv.push_back(mk(2'b10,0,1,0,0,0, 4'hA,0,0,2));
    tv.push_back(mk(2'b10,1,0,0,0,0, 4'hA,0,0,2));
    tv.push_back(mk(2'b10,1,0,0,0,0, 4'hA,0,0,2));
    tv.push_back(mk(2'b10,1,1,0,0,0, 4'hA,0,0,3));
    tv.push_back(mk(2'b10,0,1,0,0,0, 4'hA,1,0,0));
    tv.push_back(mk(2'b00,0,0,0,1,0, 4'hA,0,0,0));
    // parallel load after 2 partial bits
    tv.push_back(mk(2'b10,1,1,0,0,0, 4'hA,0,0,1));
    tv.push_back(mk(2'b10,1,1,0,0,0, 4'hA,0,0,2));
    tv.push_back(mk(2'b11,0,1,4'h6,0,0, 4'h6,1,0,0));
    tv.push_back(mk(2'b00,0,0,0,1,0, 4'h6,0,0,0));
    // direction change: 01 bits 1,1 then 10 bits 0,0,1,1
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h6,0,0,1));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h6,0,0,2));
    tv.push_back(mk(2'b10,0,1,0,0,0, 4'h6,0,0,1));
    tv.push_back(mk(2'b10,0,1,0,0,0, 4'h6,0,0,2));
    tv.push_back(mk(2'b10,1,1,0,0,0, 4'h6,0,0,3));
    tv.push_back(mk(2'b10,1,1,0,0,0, 4'h3,1,0,0));
    tv.push_back(mk(2'b00,0,0,0,0,0, 4'h3,1,0,0));
    tv.push_back(mk(2'b00,0,0,0,1,0, 4'h3,0,0,0));
    tv.push_back(mk(2'b00,0,0,0,0,0, 4'h3,0,0,0));
    // back-pressure: 5 held, A dropped, C replaces with ready
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h3,0,0,1));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h3,0,0,2));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h3,0,0,3));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h5,1,0,0));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h5,1,0,1));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h5,1,0,2));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h5,1,0,3));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h5,1,1,0));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h5,1,1,1));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h5,1,1,2));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h5,1,1,3));
    tv.push_back(mk(2'b01,1,1,0,1,0, 4'hC,1,1,0));
    tv.push_back(mk(2'b00,0,0,0,0,1, 4'hC,1,0,0));
    tv.push_back(mk(2'b00,0,0,0,1,0, 4'hC,0,0,0));
    // overrun set beats a same-cycle clear
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'hC,0,0,1));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'hC,0,0,2));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'hC,0,0,3));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h3,1,0,0));
    tv.push_back(mk(2'b01,1,1,0,0,0, 4'h3,1,0,1));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h3,1,0,2));
    tv.push_back(mk(2'b01,0,1,0,0,0, 4'h3,1,0,3));
    tv.push_back(mk(2'b01,0,1,0,0,1, 4'h3,1,1,0));
    tv.push_back(mk(2'b00,0,0,0,0,1, 4'h3,1,0,0));
    // mode 11 without sin_valid is ignored; ready drains
    tv.push_back(mk(2'b11,0,0,4'hF,1,0, 4'h3,0,0,0));

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].sel, tv[i].sin, tv[i].sv,
            tv[i].pin, tv[i].rdy, tv[i].clr);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i),
               tv[i].ep, tv[i].ev, tv[i].eo, tv[i].ec);
    end

    // reset while a word is held and overrun is set
    @(negedge clk);
    drive(2'b11, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b11, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("pre_rst", 4'h9, 1'b1, 1'b1, 3'd0);
    rst_n = 1'b0;
    #1 check("rst_full", 4'h0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
